mul_norm_shift: RTL
===================

// Module: mul_norm_shift
// PURPOSE
//  Normalizing left-shifter on the multiplier datapath. It consumes the leading-zero count produced
//  by the mul leading-one detector, shifts the product mantissa left by that count and rebiases the exponent.
//  It is a 2-stage pipeline with a valid/ready handshake, sitting between the product/LOD stage and rounding.
// PARAMETERS
//  WIDTH      24                  mantissa width; MSB is the hidden-bit position after normalization
//  EXP_WIDTH  10                  unsigned biased exponent width
//  CW         $clog2(WIDTH)       leading-zero count width (localparam)
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          input beat valid
//  in_ready   out  1          block accepts beat this cycle
//  in_mant    in   WIDTH      unnormalized mantissa
//  in_exp     in   EXP_WIDTH  biased exponent before normalization
//  in_lzc     in   CW         leading-zero count of in_mant, from the detector
//  out_valid  out  1          output beat valid
//  out_ready  in   1          downstream accepts beat
//  out_mant   out  WIDTH      normalized mantissa
//  out_exp    out  EXP_WIDTH  adjusted exponent
//  out_zero   out  1          in_mant was zero
//  out_uflow  out  1          exponent underflowed during normalization
// BEHAVIOUR
//  - Clock and reset: one clock, clk. rst is synchronous and active-high.
//  - Reset: s1_valid and out_valid clear to 0 on the next edge. out_mant, out_exp, out_zero and out_uflow clear to 0.
//    in_ready is 0 while rst is high. A reset mid-flight drops the in-flight beats silently.
//  - Handshake: a beat transfers when valid && ready on a rising edge.
//    out_valid is held stable with its data until out_ready is sampled high.
//  - Pipeline control:
//    - adv2 = !out_valid || out_ready
//    - adv1 = !s1_valid || adv2
//    - in_ready = adv1 && !rst
//    - Full throughput is 1 beat/clk. Latency from input accept to out_valid is 2 clk.
//  - Stage 1 (S1): registers the beat, computes shamt and flags, and applies the 16- and 8-bit shift steps.
//    Stage 2: applies the 4-, 2- and 1-bit steps and registers the outputs.
//  - Zero detection: in_mant == 0 or in_lzc >= WIDTH gives out_zero=1, out_mant=0, out_exp=0, out_uflow=0.
//  - Exponent: the difference is computed in EXP_WIDTH+1 bits, with no wrap-around.
//  - Normal case (in_exp > in_lzc):
//    - shamt = in_lzc
//    - out_mant = in_mant << shamt, so MSB = 1
//    - out_exp = in_exp - in_lzc
//  - Underflow case (in_exp <= in_lzc, nonzero mantissa): behaviour depends on the macro (see CONFIGURATION).
//  - Bubbles: a beat with in_valid=0 does not change S1 data when adv1=0.
//  - Simultaneous accept and emit in one cycle is legal and keeps full throughput.
// CONFIGURATION
//  Macro MUL_NORM_SUBNORM_EN
//  - Undefined (flush-to-zero), underflow case:
//    out_uflow=1, out_mant=0, out_exp=0, out_zero=0.
//  - Defined (gradual underflow), underflow case:
//    - shamt = (in_exp==0) ? 0 : in_exp-1
//    - out_mant = in_mant << shamt, which is subnormal with MSB = 0
//    - out_exp = 0
//    - out_uflow = 1
//  - Normal and zero cases are identical in both builds.
// TESTING
//  1. Reset: hold rst=1 for 3 clk with in_valid=1.
//     -> in_ready=0, out_valid=0, all outputs 0. One clk after rst falls, in_ready=1.
//  2. Normal: mant=0x00_1234, exp=100, lzc=11, out_ready=1.
//     -> 2 clk later out_mant=0x91A000, out_exp=89, uflow=0, zero=0.
//  3. Zero: mant=0, exp=50, lzc=24.
//     -> out_zero=1, out_mant=0, out_exp=0, out_uflow=0.
//  4. Underflow: mant=0x000100, exp=5, lzc=15.
//     -> without the macro: out_uflow=1, out_mant=0, out_exp=0.
//     -> with the macro: out_mant=0x001000, out_exp=0, out_uflow=1.
//  5. Backpressure: stream 6 beats at in_valid=1 with out_ready toggling 1,0,0,1.
//     -> every beat is emitted once, in order, with data unchanged.
//     -> in_ready=0 exactly when both stages are full and out_ready=0.
//  6. Reset mid-flight: assert rst for 1 clk with 2 beats in the pipe.
//     -> out_valid=0 on the next clk and neither beat ever appears.
//     -> the first post-reset beat emits after 2 clk.

Source files
------------

// File: rtl/mul_norm_shift.sv
// Normalizing left-shifter for the multiplier datapath: 2-stage pipeline with valid/ready.
// Define MUL_NORM_SUBNORM_EN for gradual underflow; otherwise underflow flushes to zero.
module mul_norm_shift #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned EXP_WIDTH = 10,
  localparam int unsigned CW       = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mant,
  input  logic [EXP_WIDTH-1:0] in_exp,
  input  logic [CW-1:0]        in_lzc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_mant,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_zero,
  output logic                 out_uflow
);

  // Shift-amount bits below SPLIT are applied in stage 2, the rest in stage 1.
  localparam int unsigned SPLIT = 3;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_mant;
  logic [SPLIT-1:0]     s1_lo;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic                 s1_zero;
  logic                 s1_uflow;

  logic adv1, adv2;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !rst;

  logic [EXP_WIDTH:0]   exp_diff;
  logic                 is_zero, is_norm;
  logic [CW-1:0]        shamt;
  logic [WIDTH-1:0]     mant_a;
  logic [EXP_WIDTH-1:0] exp_n;
  logic                 uflow_n;

  // Borrow out of the widened subtraction marks in_exp < in_lzc.
  assign exp_diff = {1'b0, in_exp} - (EXP_WIDTH+1)'(in_lzc);
  assign is_zero  = (in_mant == '0) || (32'(in_lzc) >= WIDTH);
  assign is_norm  = !exp_diff[EXP_WIDTH] && (exp_diff[EXP_WIDTH-1:0] != '0);

  always_comb begin
    shamt   = in_lzc;
    mant_a  = in_mant;
    exp_n   = exp_diff[EXP_WIDTH-1:0];
    uflow_n = 1'b0;
    if (is_zero) begin
      shamt  = '0;
      mant_a = '0;
      exp_n  = '0;
    end else if (!is_norm) begin
      uflow_n = 1'b1;
      exp_n   = '0;
`ifdef MUL_NORM_SUBNORM_EN
      shamt = (in_exp == '0) ? '0 : CW'(in_exp - EXP_WIDTH'(1));
`else
      shamt  = '0;
      mant_a = '0;
`endif
    end
    for (int unsigned k = SPLIT; k < CW; k++) begin
      if (shamt[k]) mant_a = mant_a << (1 << k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_lo    <= '0;
      s1_exp   <= '0;
      s1_zero  <= 1'b0;
      s1_uflow <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant  <= mant_a;
        s1_lo    <= shamt[SPLIT-1:0];
        s1_exp   <= exp_n;
        s1_zero  <= is_zero;
        s1_uflow <= uflow_n;
      end
    end
  end

  logic [WIDTH-1:0] mant_b;

  always_comb begin
    mant_b = s1_mant;
    for (int unsigned k = 0; k < SPLIT; k++) begin
      if (s1_lo[k]) mant_b = mant_b << (1 << k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mant  <= mant_b;
        out_exp   <= s1_exp;
        out_zero  <= s1_zero;
        out_uflow <= s1_uflow;
      end
    end
  end

endmodule
